// File: rtl/syn_pcm_fetch_if.sv
// PCM read bus plus sample stream of the Fgyrus PCM fetch block.
// master = fetch block side, slave = PCM buffer / FFT front-end side.
interface syn_pcm_fetch_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] pcm_addr;
    logic              pcm_rden;
    logic [DATA_W-1:0] pcm_rdata;
    logic              pcm_rd_valid;
    logic [DATA_W-1:0] smpl_data;
    logic              smpl_valid;
    logic              smpl_ready;
    logic              smpl_sof;
    logic              smpl_eof;

    modport master (
        output pcm_addr, pcm_rden, smpl_data, smpl_valid, smpl_sof, smpl_eof,
        input  pcm_rdata, pcm_rd_valid, smpl_ready
    );

    modport slave (
        input  pcm_addr, pcm_rden, smpl_data, smpl_valid, smpl_sof, smpl_eof,
        output pcm_rdata, pcm_rd_valid, smpl_ready
    );
endinterface

// File: rtl/syn_pcm_fetch.sv
// Fgyrus PCM read master: fetches one frame from the PCM buffer on a new-frame edge and
// streams it out through a small credit-protected FIFO with sof/eof markers.
module syn_pcm_fetch #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned RD_DELAY    = 2,
    parameter int unsigned NUM_SAMPLES = 256,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic            clk_ir,
    input  logic            rst_ih,
    input  logic            pcm_data_rdy,
    syn_pcm_fetch_if.master bus,
    output logic            busy,
    output logic            frame_done,
    output logic            missed_frame,
    output logic            rd_err
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned IgnW = $clog2(RD_DELAY + 1);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              rdy_q;
    logic              rdy_rise;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] pcm_addr_q;
    logic              pcm_rden_q;
    logic [CntW-1:0]   outst_q;
    logic [CntW-1:0]   fifo_cnt_q;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] smpl_cnt_q;
    logic [IgnW-1:0]   ign_q;
    logic              rd_err_q;
    logic              valid, eof, issue, push, pop, rd_accept, stray;
    int unsigned       used;

    assign rdy_rise  = pcm_data_rdy & ~rdy_q;
    // Returns during the post-reset window belong to reads issued before reset.
    assign rd_accept = bus.pcm_rd_valid && (ign_q == '0);
    assign push      = rd_accept && (outst_q != '0);
    assign stray     = rd_accept && (outst_q == '0);
    assign valid     = (fifo_cnt_q != '0);
    assign eof       = valid && (smpl_cnt_q == LastIdx);
    assign pop       = valid && bus.smpl_ready;

    // Slot accounting: every issued read holds a slot until its sample pops; a pop in this
    // cycle frees its slot for the read issued now, sustaining one read per cycle.
    always_comb begin
        used  = 32'(fifo_cnt_q) + 32'(outst_q) - 32'(pop);
        issue = (state_q == StFetch) && (used < FIFO_DEPTH);
    end

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        busy         = 1'b0;
        frame_done   = 1'b0;
        missed_frame = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rdy_rise) begin
                    state_d   = StFetch;
                    rd_addr_d = '0;
                end
            end
            StFetch: begin
                busy         = 1'b1;
                missed_frame = rdy_rise;
                if (issue) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (rd_addr_q == LastIdx) state_d = StDrain;
                end
            end
            StDrain: begin
                busy         = 1'b1;
                missed_frame = rdy_rise;
                if (pop && eof) state_d = StDone;
            end
            StDone: begin
                frame_done = 1'b1;
                if (rdy_rise) begin
                    state_d   = StFetch;
                    rd_addr_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            state_q    <= StIdle;
            rdy_q      <= 1'b0;
            rd_addr_q  <= '0;
            pcm_addr_q <= '0;
            pcm_rden_q <= 1'b0;
            outst_q    <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            smpl_cnt_q <= '0;
            ign_q      <= IgnW'(RD_DELAY);
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= pcm_data_rdy;
            rd_addr_q  <= rd_addr_d;
            pcm_rden_q <= issue;
            if (issue) pcm_addr_q <= rd_addr_q;
            unique case ({issue, push})
                2'b10:   outst_q <= outst_q + CntW'(1);
                2'b01:   outst_q <= outst_q - CntW'(1);
                default: outst_q <= outst_q;
            endcase
            fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                smpl_cnt_q <= eof ? '0 : smpl_cnt_q + 1'b1;
            end
            if (ign_q != '0) ign_q <= ign_q - 1'b1;
            if (stray) rd_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_ir) begin
        if (push) mem_q[wr_ptr_q] <= bus.pcm_rdata;
    end

    assign bus.pcm_addr   = pcm_addr_q;
    assign bus.pcm_rden   = pcm_rden_q;
    assign bus.smpl_valid = valid;
    assign bus.smpl_data  = valid ? mem_q[rd_ptr_q] : '0;
    assign bus.smpl_sof   = valid && (smpl_cnt_q == '0);
    assign bus.smpl_eof   = eof;
    assign rd_err         = rd_err_q;
endmodule

// File: tb/tb_syn_pcm_fetch.sv
// Bench for syn_pcm_fetch: PCM buffer model returning addr*3+offset, a frame-level sample
// scoreboard, a scenario table and hand-written reset/error/back-to-back sequences.
module tb_syn_pcm_fetch;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned RD = 2;
    localparam int unsigned NS = 8;
    localparam int unsigned FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    logic busy, frame_done, missed_frame, rd_err;
    always #5 clk = ~clk;

    syn_pcm_fetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    syn_pcm_fetch #(
        .DATA_W(DW), .ADDR_W(AW), .RD_DELAY(RD), .NUM_SAMPLES(NS), .FIFO_DEPTH(FD)
    ) dut (
        .clk_ir(clk), .rst_ih(rst), .pcm_data_rdy(rdy), .bus(bus),
        .busy(busy), .frame_done(frame_done), .missed_frame(missed_frame), .rd_err(rd_err)
    );

    // PCM buffer: fixed-latency read pipe, not affected by the DUT reset.
    logic [RD-1:0] vpipe = '0;
    logic [AW-1:0] apipe [RD];
    logic          inject = 1'b0;
    logic [DW-1:0] data_off = '0;
    always @(posedge clk) begin
        vpipe    <= {vpipe[RD-2:0], bus.pcm_rden};
        apipe[0] <= bus.pcm_addr;
        for (int i = 1; i < RD; i++) apipe[i] <= apipe[i-1];
    end
    assign bus.pcm_rd_valid = vpipe[RD-1] | inject;
    assign bus.pcm_rdata    = DW'(apipe[RD-1]) * 3 + data_off;

    typedef struct {
        string name;
        int    mode;
        int    frames;
        bit    rerise;
        int    exp_samples;
        int    exp_sof;
        int    exp_eof;
        int    exp_done;
        int    exp_missed;
    } vec_t;
    vec_t vecs[5];

    int tests = 0, fails = 0;
    int cnt_samples = 0, cnt_sof = 0, cnt_eof = 0, cnt_done = 0, cnt_missed = 0;
    int issued = 0, accepted = 0, exp_k = 0, exp_raddr = 0, cyc = 0, ready_mode = 0;
    bit hold = 1'b0;
    logic [DW-1:0] hold_data;
    logic hold_sof, hold_eof;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [DW-1:0] e;
        if (rst) begin
            exp_k = 0; exp_raddr = 0; issued = 0; accepted = 0; hold = 1'b0;
        end else begin
            if (bus.pcm_rden) begin
                check("rd_addr", 64'(bus.pcm_addr), 64'(exp_raddr));
                check("occupancy_over_depth", 64'((issued + 1 - accepted) > int'(FD)), 64'(0));
                issued++;
                exp_raddr = (exp_raddr + 1) % NS;
            end
            if (hold)
                check("hold_stable",
                      {bus.smpl_valid, bus.smpl_data, bus.smpl_sof, bus.smpl_eof},
                      {1'b1, hold_data, hold_sof, hold_eof});
            if (bus.smpl_valid && bus.smpl_ready) begin
                e = DW'(exp_k) * 3 + data_off;
                check("sample", {bus.smpl_data, bus.smpl_sof, bus.smpl_eof},
                      {e, exp_k == 0, exp_k == int'(NS) - 1});
                cnt_samples++;
                if (bus.smpl_sof) cnt_sof++;
                if (bus.smpl_eof) cnt_eof++;
                accepted++;
                exp_k = (exp_k + 1) % NS;
            end
            hold      = bus.smpl_valid && !bus.smpl_ready;
            hold_data = bus.smpl_data;
            hold_sof  = bus.smpl_sof;
            hold_eof  = bus.smpl_eof;
            if (frame_done) cnt_done++;
            if (missed_frame) cnt_missed++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       bus.smpl_ready = 1'b1;
            1:       bus.smpl_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: bus.smpl_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wait_done(input string name, input int budget);
        int base = cnt_done;
        int n = 0;
        while (cnt_done == base && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 64'(cnt_done > base), 64'(1));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.pcm_addr, bus.pcm_rden, bus.smpl_data, bus.smpl_valid, bus.smpl_sof,
                    bus.smpl_eof, busy, frame_done, missed_frame, rd_err});
    endfunction

    task automatic run_vec(input vec_t v);
        int s0 = cnt_samples, f0 = cnt_sof, e0 = cnt_eof, d0 = cnt_done, m0 = cnt_missed;
        int fb, n;
        ready_mode = v.mode;
        for (int f = 0; f < v.frames; f++) begin
            if (v.mode == 2) begin
                data_off = $urandom;
                repeat ($urandom_range(0, 3)) tick();
            end
            fb = cnt_samples;
            rdy = 1'b1;
            tick();
            check({v.name, "_busy_run"}, 64'(busy), 64'(1));
            if (!v.rerise) begin
                rdy = 1'b0;
            end else begin
                n = 0;
                while (cnt_samples - fb < 3 && n < 100) begin
                    tick();
                    n++;
                end
                rdy = 1'b0;
                tick();
                rdy = 1'b1;
                tick();
            end
            wait_done(v.name, 200);
            rdy = 1'b0;
        end
        tick();
        tick();
        check({v.name, "_samples"}, 64'(cnt_samples - s0), 64'(v.exp_samples));
        check({v.name, "_sof"}, 64'(cnt_sof - f0), 64'(v.exp_sof));
        check({v.name, "_eof"}, 64'(cnt_eof - e0), 64'(v.exp_eof));
        check({v.name, "_frame_done"}, 64'(cnt_done - d0), 64'(v.exp_done));
        check({v.name, "_missed"}, 64'(cnt_missed - m0), 64'(v.exp_missed));
        check({v.name, "_busy_idle"}, 64'(busy), 64'(0));
        data_off = '0;
    endtask

    initial begin
        int n, base, s0, m0;
        vecs[0] = '{"basic",   0, 1, 1'b0,  8, 1, 1, 1, 0};
        vecs[1] = '{"bp1001",  1, 1, 1'b0,  8, 1, 1, 1, 0};
        vecs[2] = '{"rerise",  0, 1, 1'b1,  8, 1, 1, 1, 1};
        vecs[3] = '{"b2b",     0, 2, 1'b0, 16, 2, 2, 2, 0};
        vecs[4] = '{"rand_bp", 2, 3, 1'b0, 24, 3, 3, 3, 0};
        bus.smpl_ready = 1'b0;

        // Reset state, both while held and after release with no frame edge.
        repeat (3) tick();
        check("reset_held_outputs", all_outs(), 64'(0));
        rst = 1'b0;
        tick();
        tick();
        check("reset_released_outputs", all_outs(), 64'(0));

        // First sample appears RD+1 cycles after the first rden.
        ready_mode = 0;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        n = 0;
        while (!bus.pcm_rden && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (!bus.smpl_valid && n < 20) begin
            tick();
            n++;
        end
        check("first_valid_latency", 64'(n), 64'(RD + 1));
        wait_done("latency", 200);
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Rising edge in the DONE cycle starts the next frame at address 0.
        ready_mode = 0;
        s0 = cnt_samples;
        m0 = cnt_missed;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        base = cnt_eof;
        n = 0;
        while (cnt_eof == base && n < 100) begin
            tick();
            n++;
        end
        check("done_cycle_frame_done", 64'(frame_done), 64'(1));
        rdy = 1'b1;
        check("done_cycle_no_missed", 64'(missed_frame), 64'(0));
        tick();
        rdy = 1'b0;
        check("done_rise_busy", 64'(busy), 64'(1));
        wait_done("done_rise", 200);
        tick();
        check("done_rise_samples", 64'(cnt_samples - s0), 64'(2 * NS));
        check("done_rise_missed", 64'(cnt_missed - m0), 64'(0));

        // Stray read data while idle: sticky error, no output, later frame still fine.
        check("rd_err_before", 64'(rd_err), 64'(0));
        inject = 1'b1;
        tick();
        tick();
        inject = 1'b0;
        check("rd_err_set", 64'(rd_err), 64'(1));
        for (int i = 0; i < 3; i++) begin
            check("stray_no_valid", 64'(bus.smpl_valid), 64'(0));
            tick();
        end
        check("rd_err_sticky", 64'(rd_err), 64'(1));
        run_vec(vecs[0]);
        check("rd_err_sticky_after_frame", 64'(rd_err), 64'(1));

        // One-cycle reset mid-fetch with reads still in flight.
        ready_mode = 0;
        base = issued;
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        n = 0;
        while (issued - base < 3 && n < 50) begin
            tick();
            n++;
        end
        check("rden_before_reset", 64'(bus.pcm_rden), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset_outputs", all_outs(), 64'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_reset_quiet", {63'(bus.smpl_valid), rd_err}, 64'(0));
        end
        run_vec(vecs[0]);
        check("post_reset_rd_err", 64'(rd_err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
